// File: rtl/dm_byte_lane.sv
// Data memory for the MEM stage: byte-lane aligned, lane-masked clocked writes,
// combinational word reads, and live plus sticky access-error reporting.
module dm_byte_lane #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        addr_err,
    output logic        err_sticky,
    output logic [31:0] err_addr
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    // Byte span of the array; 33 bits so the compare stays exact for large depths.
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    // Places the raw store value onto the lanes selected by be. Bit 32 of the
    // result is the legality flag; illegal or empty patterns yield zero data.
    function automatic logic [32:0] align_lanes(input logic [3:0] be_i, input logic [31:0] wd_i);
        logic [32:0] res;
        case (be_i)
            4'b1111: res = {1'b1, wd_i};
            4'b0011: res = {1'b1, 16'h0000, wd_i[15:0]};
            4'b1100: res = {1'b1, wd_i[15:0], 16'h0000};
            4'b0001: res = {1'b1, 24'h00_0000, wd_i[7:0]};
            4'b0010: res = {1'b1, 16'h0000, wd_i[7:0], 8'h00};
            4'b0100: res = {1'b1, 8'h00, wd_i[7:0], 16'h0000};
            4'b1000: res = {1'b1, wd_i[7:0], 24'h00_0000};
            default: res = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    logic [31:0]           mem_q [DEPTH];
    logic                  err_sticky_q, err_sticky_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic [31:0]           offset_s;
    logic                  in_range_s;
    logic [DEPTH_LOG2-1:0] word_s;
    logic [31:0]           wdata_s;
    logic                  be_legal_s;
    logic                  misaligned_s;
    logic                  addr_err_s;
    logic [3:0]            lane_we_s;
    logic [31:0]           rd_s;

    // Address decode, lane alignment, per-lane write enables, read mux and live error.
    always_comb begin
        offset_s     = addr - BASE_ADDR;
        in_range_s   = ({1'b0, offset_s} < SPAN);
        word_s       = offset_s[DEPTH_LOG2+1:2];
        {be_legal_s, wdata_s} = align_lanes(be, wd);
        misaligned_s = we && !be_legal_s;
        addr_err_s   = (we || re) && (!in_range_s || misaligned_s);
        if (we && in_range_s && be_legal_s) begin
            lane_we_s = be;
        end else begin
            lane_we_s = 4'b0000;
        end
        if (in_range_s) begin
            rd_s = mem_q[word_s];
        end else begin
            rd_s = 32'h0000_0000;
        end
    end

    // First-error capture: only the first error after reset records its address.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (addr_err_s && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = addr;
        end else begin
            err_sticky_d = err_sticky_q;
            err_addr_d   = err_addr_q;
        end
    end

    // Memory array: cleared on reset (which also blocks any write), else lane-masked write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we_s[k]) begin
                    mem_q[word_s][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= 32'h0000_0000;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign rd         = rd_s;
    assign addr_err   = addr_err_s;
    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_dm_byte_lane.sv
// Directed bench for dm_byte_lane with hand-computed expected values.
module tb_dm_byte_lane;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        addr_err;
    logic        err_sticky;
    logic [31:0] err_addr;

    int total_cnt;
    int bad_cnt;

    dm_byte_lane #(
        .DEPTH_LOG2(10),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .addr      (addr),
        .be        (be),
        .wd        (wd),
        .rd        (rd),
        .addr_err  (addr_err),
        .err_sticky(err_sticky),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        we   = w;
        re   = r;
        addr = a;
        be   = b;
        wd   = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("rst_rd", rd, 32'h0);
        check_val("rst_sticky", {31'h0, err_sticky}, 32'h0);
        check_val("rst_erraddr", err_addr, 32'h0);
        check_val("rst_adderr", {31'h0, addr_err}, 32'h0);

        // Word store
        drive(1'b1, 1'b0, 32'h10, 4'b1111, 32'hDEAD_BEEF);
        check_val("word_old", rd, 32'h0);
        check_val("word_err", {31'h0, addr_err}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("word_rd", rd, 32'hDEAD_BEEF);
        check_val("word_rd_err", {31'h0, addr_err}, 32'h0);

        // Byte lanes
        drive(1'b1, 1'b0, 32'h12, 4'b0100, 32'h0000_00A5);
        tick();
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("byte2", rd, 32'hDEA5_BEEF);
        drive(1'b1, 1'b0, 32'h10, 4'b0001, 32'h1122_3344);
        tick();
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("byte0", rd, 32'hDEA5_BE44);
        drive(1'b1, 1'b0, 32'h11, 4'b0010, 32'h0000_0077);
        tick();
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("byte1", rd, 32'hDEA5_7744);

        // Halfword high
        drive(1'b1, 1'b0, 32'h22, 4'b1100, 32'h0000_CAFE);
        check_val("half_old", rd, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
        check_val("half_hi", rd, 32'hCAFE_0000);
        drive(1'b1, 1'b0, 32'h20, 4'b0011, 32'hFFFF_1234);
        tick();
        drive(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
        check_val("half_lo", rd, 32'hCAFE_1234);

        // Misaligned store (be=0000)
        drive(1'b1, 1'b0, 32'h21, 4'b0000, 32'hFFFF_FFFF);
        check_val("mis_err", {31'h0, addr_err}, 32'h1);
        check_val("mis_nosticky", {31'h0, err_sticky}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
        check_val("mis_nowrite", rd, 32'hCAFE_1234);
        check_val("mis_sticky", {31'h0, err_sticky}, 32'h1);
        check_val("mis_erraddr", err_addr, 32'h21);

        // Illegal pattern: no write
        drive(1'b1, 1'b0, 32'h20, 4'b0110, 32'hFFFF_FFFF);
        check_val("illegal_err", {31'h0, addr_err}, 32'h1);
        tick();
        drive(1'b0, 1'b1, 32'h20, 4'h0, 32'h0);
        check_val("illegal_nowr", rd, 32'hCAFE_1234);

        // Later error leaves err_addr
        drive(1'b0, 1'b1, 32'h5000, 4'h0, 32'h0);
        check_val("oor_re_err", {31'h0, addr_err}, 32'h1);
        tick();
        check_val("later_erraddr", err_addr, 32'h21);

        // Out of range store
        drive(1'b1, 1'b0, 32'h1000, 4'b1111, 32'h0BAD_0BAD);
        check_val("oor_err", {31'h0, addr_err}, 32'h1);
        check_val("oor_rd", rd, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        check_val("oor_nowrap", rd, 32'h0);
        drive(1'b0, 1'b0, 32'h1000, 4'h0, 32'h0);
        check_val("oor_idle_err", {31'h0, addr_err}, 32'h0);

        // Last word accepted
        drive(1'b1, 1'b0, 32'h0FFC, 4'b1111, 32'hAABB_CCDD);
        check_val("last_err", {31'h0, addr_err}, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0FFC, 4'h0, 32'h0);
        check_val("last_rd", rd, 32'hAABB_CCDD);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 4'h0, 32'h0);
        check_val("wrap_err", {31'h0, addr_err}, 32'h1);
        check_val("wrap_rd", rd, 32'h0);

        // Reset mid-operation dominates a write
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h30, 4'b1111, 32'h1234_5678);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h30, 4'h0, 32'h0);
        check_val("rst2_rd30", rd, 32'h0);
        check_val("rst2_sticky", {31'h0, err_sticky}, 32'h0);
        check_val("rst2_erraddr", err_addr, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 4'h0, 32'h0);
        check_val("rst2_rd10", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/dm_byte_lane.md
Name: dm_byte_lane

Overview:
- Data memory for the MEM stage.
- Consumes the 4-bit byte-enable from the store-lane decoder, plus the ALU address and the raw rt store value.
- Aligns store data onto byte lanes and performs a clocked, lane-masked write.
- Provides a combinational word read for the MEM/WB latch, and flags out-of-range and misaligned accesses (live and sticky).

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words = 4 KB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we  input  1  MEM-stage memory write enable (store instruction valid)
- re  input  1  MEM-stage memory read enable (load instruction valid)
- addr  input  32  byte address from ALU (EX/MEM latch)
- be  input  4  byte-lane enables from the store-lane decoder
- wd  input  32  raw store value (rt), unaligned
- rd  output  32  full word at addr, unmasked
- addr_err  output  1  live flag: current access out of range or misaligned
- err_sticky  output  1  latched error, held until reset
- err_addr  output  32  addr of the first error since reset

Behaviour:
- Index: word = (addr - BASE_ADDR) >> 2, using bits [DEPTH_LOG2+1:2].
- Range: in_range = (addr - BASE_ADDR) < 4*2^DEPTH_LOG2, unsigned compare on the 32-bit difference. Wrap below BASE_ADDR is therefore out of range.
- Lane alignment of wd into wdata, combinational:
  - be=1111 -> wd.
  - be=0011 -> {16'b0, wd[15:0]}; be=1100 -> {wd[15:0], 16'b0}.
  - Single-bit be (0001/0010/0100/1000) -> wd[7:0] placed in lanes 0/1/2/3 respectively; other lanes 0.
  - Any other be pattern -> wdata = 0, and the pattern counts as misaligned.
- Write:
  - At posedge, if we && !reset && in_range && be is legal and nonzero, each lane k with be[k]=1 takes wdata[8k+7:8k].
  - Lanes with be[k]=0 are unchanged.
- misaligned = we && (be==0000 or be not in the legal set).
  - be=0000 with we=1 (e.g. sh at addr[1:0]=01) writes nothing and raises addr_err.
- Read:
  - rd = mem[word] combinationally when in_range; 32'h0 when out of range.
  - re has no effect on rd. It only qualifies range errors.
  - Same-cycle read of a word being written shows the OLD value; the new value is visible after the edge.
- addr_err = (we || re) && (!in_range || misaligned), combinational.
- Sticky error (registered):
  - At posedge, if addr_err && !err_sticky: err_sticky<=1, err_addr<=addr.
  - Later errors do not update err_addr.
- Reset (synchronous, reset=1 at posedge):
  - All memory words <= 0; err_sticky <= 0; err_addr <= 0.
  - Reset dominates any simultaneous write: no write occurs that cycle.
- Reset value of outputs:
  - rd = 0 after reset (memory cleared).
  - addr_err is combinational and reflects live inputs.
  - err_sticky = 0; err_addr = 0.
- Latency: write 1 cycle (edge-committed); read 0 cycles.

Test Plan:
- Word store: reset, then we=1, addr=0x10, be=1111, wd=0xDEADBEEF for one cycle; next cycle we=0, re=1, addr=0x10 -> rd=0xDEADBEEF, addr_err=0.
- Byte lanes: after word 0x10 = 0xDEADBEEF, store be=0100, wd=0x000000A5, addr=0x12 -> rd@0x10 = 0xDEA5BEEF. Then be=0001, wd=0x11223344, addr=0x10 -> rd = 0xDEA5BE44.
- Halfword: be=1100, wd=0x0000CAFE, addr=0x22, over a zero word -> rd@0x20 = 0xCAFE0000. Same cycle, rd still 0x00000000 before the edge.
- Misaligned store: we=1, be=0000, addr=0x21, wd=0xFFFFFFFF -> addr_err=1 that cycle, word 0x20 unchanged. Next cycle err_sticky=1, err_addr=0x21. A later error at addr=0x5000 leaves err_addr=0x21.
- Out of range (DEPTH_LOG2=10): we=1, be=1111, addr=0x1000 -> no write, rd=0, addr_err=1. addr=0x0FFC is accepted (last word). re=1 at 0xFFFFFFFC -> addr_err=1.
- Reset mid-operation: assert reset together with we=1, addr=0x30, be=1111, wd=0x12345678 -> after the edge rd@0x30 = 0, err_sticky = 0, and earlier contents of 0x10 are cleared to 0.
